shifter_seq: RTL and testbench
==============================

Name: shifter_seq

Overview:
Parametrised multi-cycle shifter for the CPU execute stage, succeeding the fixed 32-bit one-bit-per-cycle shifter. Supports data width XLEN and a configurable shift distance per cycle (STEP). Uses an explicit start/ready/valid handshake and a flush input, so the pipeline can issue, stall on and cancel shift operations. Decodes RISC-V funct3/alt bits for SLL, SRL and SRA, plus optional Zbb rotates.

Parameters:
XLEN, 32, data width; power of two, 8..64.
STEP, 4, maximum bits shifted per cycle; power of two, 1..XLEN.

Ports:
i_clk_n  input  1  clock; all state updates on its rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  request; accepted when i_start && o_ready && legal op.
i_in_a  input  XLEN  operand to shift.
i_in_b  input  $clog2(XLEN)  shift amount (upper operand bits already dropped upstream).
i_funct3  input  3  001 = left, 101 = right; all other codes are illegal.
i_op_alt  input  1  right shift: 0 = logical, 1 = arithmetic.
i_op_rot  input  1  rotate select (effective only with SHIFTER_ROTATE_EN).
i_flush  input  1  synchronous cancel of an in-flight operation.
o_ready  output  1  can accept a start this cycle.
o_busy  output  1  operation in progress (SHIFT state).
o_valid  output  1  one-cycle pulse: o_result is the new result.
o_result  output  XLEN  result register; holds its value until the next accepted start completes.

Behaviour:
- Reset (asynchronous, any time including mid-shift): state=IDLE, o_result=0, o_valid=0, o_busy=0, o_ready=1, internal count=0.
- States:
  - IDLE: o_ready=1.
  - SHIFT: o_busy=1, o_ready=0.
  - DONE: o_valid=1, o_ready=1.
- On accept:
  - Latch i_in_a into the work register.
  - Latch i_in_b into the remaining count.
  - Latch the op: SLL, SRL, SRA, ROL or ROR. i_op_rot takes priority over i_op_alt.
  - If i_in_b==0, go to DONE; otherwise go to SHIFT.
- Illegal i_funct3 with i_start: ignored; no state change, no o_valid.
- SHIFT, each cycle:
  - d = min(remaining, STEP).
  - Shift the work register by d: SLL zero-fills; SRL zero-fills; SRA fills with the original bit XLEN-1; ROL/ROR wrap bits around.
  - remaining -= d.
  - When remaining reaches 0, go to DONE and write the work register to o_result on that same edge.
- DONE lasts one cycle, then returns to IDLE. A start accepted in DONE goes directly to SHIFT or DONE (back-to-back issue, no bubble).
- Latency: an operation accepted at edge 0 asserts o_valid during the cycle after edge ceil(N/STEP)+1. For N=0, o_valid follows edge 1. STEP=XLEN therefore gives fixed 2-cycle latency.
- i_flush:
  - In SHIFT: return to IDLE at the next edge; no o_valid; o_result unchanged.
  - In DONE: o_valid is still seen this cycle.
  - i_flush has priority over i_start in the same cycle; the start is not accepted.
- i_in_* and op inputs are don't-care outside the accept cycle.
- o_busy==1 implies o_ready==0 and o_valid==0.

Optional Feature:
SHIFTER_ROTATE_EN.
- Defined: i_op_rot=1 selects ROL (funct3 001) or ROR (funct3 101). Rotation distance = i_in_b mod XLEN.
- Undefined: i_op_rot is ignored (lint-waived unused), no rotate datapath is built, and rotate requests execute as SLL/SRL/SRA per i_op_alt.

Test Plan:
- XLEN=32, STEP=4: SLL of 0x0000_0001 by 31 -> 8 SHIFT cycles; o_valid in cycle after edge 9; o_result=0x8000_0000.
- SRA of 0x8000_0000 by 5 -> 2 SHIFT cycles (4 then 1); o_result=0xFC00_0000. SRL of the same operand -> 0x0400_0000.
- Amount 0 with SLL of 0xDEAD_BEEF -> o_valid after edge 1, o_result=0xDEAD_BEEF; o_busy never asserted. Then a back-to-back start in DONE is accepted.
- i_flush two cycles into SRL by 20 -> IDLE, no o_valid, o_result keeps its prior value. Then i_rst_n low mid-shift -> all outputs return to reset values immediately.
- SHIFTER_ROTATE_EN, ROR of 0x0000_00F1 by 4 -> 0x1000_000F. Without the macro, the same stimulus gives 0x0000_000F (SRL).
- STEP=1 and STEP=32 sweeps against a reference model, all ops, amounts 0..31, random operands -> results match; latency equals ceil(N/STEP)+1.

Source files
------------

// File: rtl/shifter_seq.sv
// Multi-cycle SLL/SRL/SRA shifter, up to STEP bits per cycle; SHIFTER_ROTATE_EN adds Zbb ROL/ROR.
// Latency: ceil(N/STEP)+1 edges from the start cycle to o_valid; a zero amount completes on the accept edge.
// Backpressure: o_ready is low while shifting; i_flush cancels a shift and leaves o_result untouched.
module shifter_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic                    i_clk_n,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [XLEN-1:0]         i_in_a,
    input  logic [$clog2(XLEN)-1:0] i_in_b,
    input  logic [2:0]              i_funct3,
    input  logic                    i_op_alt,
    input  logic                    i_op_rot,
    input  logic                    i_flush,
    output logic                    o_ready,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic [XLEN-1:0]         o_result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW:0] STEP_W = STEP[CW:0];

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] work, work_nxt;
    logic [CW-1:0]   rem, rem_nxt;
    logic [CW:0]     d_amt;
    logic            op_left, op_arith;
    logic            legal, accept, last;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [CW:0] XLEN_W = XLEN[CW:0];
    logic op_rot;
`else
    logic unused_rot;
    assign unused_rot = i_op_rot;
`endif

    assign legal = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    // d_amt never exceeds rem, so its low CW bits are exact.
    always_comb begin
        d_amt    = ({1'b0, rem} > STEP_W) ? STEP_W : {1'b0, rem};
        rem_nxt  = rem - d_amt[CW-1:0];
        last     = (rem_nxt == '0);
        work_nxt = op_left ? (work << d_amt) : (work >> d_amt);
        if (!op_left && op_arith) begin
            work_nxt = $signed(work) >>> d_amt;
        end
`ifdef SHIFTER_ROTATE_EN
        if (op_rot) begin
            work_nxt = op_left ? ((work << d_amt) | (work >> (XLEN_W - d_amt)))
                               : ((work >> d_amt) | (work << (XLEN_W - d_amt)));
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_busy    = 1'b0;
        o_valid   = 1'b0;
        case (state)
            S_IDLE:  o_ready = 1'b1;
            S_SHIFT: o_busy  = 1'b1;
            S_DONE: begin
                o_valid = 1'b1;
                o_ready = 1'b1;
            end
            default: ;
        endcase
        accept = i_start && o_ready && legal && !i_flush;
        case (state)
            S_SHIFT: begin
                if (i_flush) begin
                    state_nxt = S_IDLE;
                end else if (last) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                if (accept) begin
                    state_nxt = (i_in_b == '0) ? S_DONE : S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            work     <= '0;
            rem      <= '0;
            op_left  <= 1'b0;
            op_arith <= 1'b0;
            o_result <= '0;
`ifdef SHIFTER_ROTATE_EN
            op_rot   <= 1'b0;
`endif
        end else if (accept) begin
            work    <= i_in_a;
            rem     <= i_in_b;
            op_left <= (i_funct3 == 3'b001);
`ifdef SHIFTER_ROTATE_EN
            op_rot   <= i_op_rot;
            op_arith <= i_op_alt && !i_op_rot;
`else
            op_arith <= i_op_alt;
`endif
            if (i_in_b == '0) begin
                o_result <= i_in_a;
            end
        end else if (state == S_SHIFT) begin
            if (i_flush) begin
                rem <= '0;
            end else begin
                work <= work_nxt;
                rem  <= rem_nxt;
                if (last) begin
                    o_result <= work_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_shifter_seq.sv
// Scoreboard bench: three shifter_seq instances (STEP 4, 1, 32) share stimulus; each has its own expect queue and monitor.
module tb_shifter_seq;
    localparam int XLEN = 32;
    localparam int NI   = 3;

    typedef struct packed {
        logic [31:0] exp;
        int          b;
        int          cyc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] in_a;
    logic [4:0]  in_b;
    logic [2:0]  funct3;
    logic        op_alt, op_rot;
    logic        flush [NI];
    logic        rdy   [NI];
    logic        busy  [NI];
    logic        vld   [NI];
    logic [31:0] res   [NI];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    ent_t q0[$], q1[$], q2[$];
    logic [31:0] last0 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Whole-word reference: the full shift applied at once.
    function automatic logic [31:0] model(input logic [31:0] a, input int n, input logic [2:0] f,
                                          input bit alt, input bit rot);
        logic [63:0] dbl;
        logic        left;
        left = (f == 3'b001);
`ifdef SHIFTER_ROTATE_EN
        if (rot) begin
            dbl = {a, a};
            if (left) begin
                dbl = dbl << n;
                return dbl[63:32];
            end
            dbl = dbl >> n;
            return dbl[31:0];
        end
`else
        if (rot) begin end
`endif
        if (left) return a << n;
        if (!alt) return a >> n;
        dbl = {{32{a[31]}}, a};
        dbl = dbl >> n;
        return dbl[31:0];
    endfunction

    genvar k;
    generate
        for (k = 0; k < NI; k++) begin : g_dut
            localparam int STEP_I = (k == 0) ? 4 : (k == 1) ? 1 : 32;
            shifter_seq #(.XLEN(XLEN), .STEP(STEP_I)) u_dut (
                .i_clk_n  (clk),
                .i_rst_n  (rst_n),
                .i_start  (start),
                .i_in_a   (in_a),
                .i_in_b   (in_b),
                .i_funct3 (funct3),
                .i_op_alt (op_alt),
                .i_op_rot (op_rot),
                .i_flush  (flush[k]),
                .o_ready  (rdy[k]),
                .o_busy   (busy[k]),
                .o_valid  (vld[k]),
                .o_result (res[k])
            );

            always @(negedge clk) begin : mon
                ent_t e;
                int   n;
                if (rst_n) begin
                    if (busy[k]) begin
                        chk($sformatf("busy_excl_i%0d", k), {30'd0, rdy[k], vld[k]}, 32'd0);
                    end
                    if (vld[k]) begin
                        n = 0;
                        e = '0;
                        if (k == 0) begin
                            n = q0.size();
                            if (n > 0) e = q0.pop_front();
                        end else if (k == 1) begin
                            n = q1.size();
                            if (n > 0) e = q1.pop_front();
                        end else begin
                            n = q2.size();
                            if (n > 0) e = q2.pop_front();
                        end
                        checks++;
                        if (n == 0) begin
                            errors++;
                            $display("FAIL spurious_valid_i%0d actual=valid(res=%h) required=no valid", k, res[k]);
                        end else begin
                            chk($sformatf("result_i%0d_b%0d", k, e.b), res[k], e.exp);
                            chk($sformatf("latency_i%0d_b%0d", k, e.b), cyc,
                                e.cyc + (e.b + STEP_I - 1) / STEP_I);
                        end
                    end
                end
            end
        end
    endgenerate

    // Entered at a negedge; waits until every instance can accept, drives one start cycle.
    task automatic issue(input logic [31:0] a, input int b, input logic [2:0] f, input bit alt,
                         input bit rot, input bit [2:0] pmask, input bit fl0);
        int   w = 0;
        ent_t e;
        while (!(rdy[0] && rdy[1] && rdy[2]) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("issue_wait_timeout", 32'(w >= 200), 32'd0);
        in_a     = a;
        in_b     = 5'(b);
        funct3   = f;
        op_alt   = alt;
        op_rot   = rot;
        flush[0] = fl0;
        start    = 1'b1;
        if (f == 3'b001 || f == 3'b101) begin
            e.exp = model(a, b, f, alt, rot);
            e.b   = b;
            e.cyc = cyc + 1;
            if (pmask[0]) begin q0.push_back(e); last0 = e.exp; end
            if (pmask[1]) q1.push_back(e);
            if (pmask[2]) q2.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        flush[0] = 1'b0;
        in_a     = $urandom;
        in_b     = 5'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (((q0.size() + q1.size() + q2.size()) != 0 || !(rdy[0] && rdy[1] && rdy[2])) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 32'(w >= 500), 32'd0);
    endtask

    initial begin
        logic [2:0] f;
        rst_n  = 1'b0;
        start  = 1'b0;
        in_a   = '0;
        in_b   = '0;
        funct3 = 3'b001;
        op_alt = 1'b0;
        op_rot = 1'b0;
        for (int i = 0; i < NI; i++) flush[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_ready_i%0d", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst_busy_i%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst_valid_i%0d", i), 32'(vld[i]), 32'd0);
            chk($sformatf("rst_result_i%0d", i), res[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h0000_0001, 31, 3'b001, 1'b0, 1'b0, 3'b111, 1'b0);
        issue(32'h8000_0000, 5, 3'b101, 1'b1, 1'b0, 3'b111, 1'b0);
        issue(32'h8000_0000, 5, 3'b101, 1'b0, 1'b0, 3'b111, 1'b0);
        drain();
        issue(32'hDEAD_BEEF, 0, 3'b001, 1'b0, 1'b0, 3'b111, 1'b0);
        chk("zero_amt_busy", 32'(busy[0]), 32'd0);
        issue(32'h1234_5678, 7, 3'b101, 1'b0, 1'b0, 3'b111, 1'b0);
        issue(32'h0000_00F1, 4, 3'b101, 1'b0, 1'b1, 3'b111, 1'b0);
        drain();

        issue(32'hFFFF_0000, 3, 3'b000, 1'b0, 1'b0, 3'b111, 1'b0);
        chk("illegal_busy", 32'(busy[0]), 32'd0);
        chk("illegal_ready", 32'(rdy[0]), 32'd1);
        drain();

        issue(32'hA5A5_0000, 20, 3'b101, 1'b0, 1'b0, 3'b110, 1'b1);
        chk("flush_prio_busy", 32'(busy[0]), 32'd0);
        drain();

        issue(32'hF000_000F, 20, 3'b101, 1'b0, 1'b0, 3'b110, 1'b0);
        @(negedge clk);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        chk("flush_ready", 32'(rdy[0]), 32'd1);
        chk("flush_busy", 32'(busy[0]), 32'd0);
        chk("flush_result_hold", res[0], last0);
        drain();

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                do f = 3'($urandom_range(0, 7)); while (f == 3'b001 || f == 3'b101);
            end else begin
                f = $urandom_range(0, 1) ? 3'b001 : 3'b101;
            end
            issue($urandom, $urandom_range(0, 31), f, 1'($urandom), 1'($urandom), 3'b111, 1'b0);
        end
        drain();

        issue(32'h0000_0001, 31, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("midrst_ready_i%0d", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("midrst_busy_i%0d", i), 32'(busy[i]), 32'd0);
            chk($sformatf("midrst_valid_i%0d", i), 32'(vld[i]), 32'd0);
            chk($sformatf("midrst_result_i%0d", i), res[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
